// File: rtl/mult_pkg.sv
// Shared state encoding and default sizing for the sequential shift-and-add multiplier.
// Used by seq_mult16_ctrl and mul_add_step.
package mult_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_add_step.sv
// One shift-and-add step of the multiplier: conditionally adds M to the upper half of P,
// keeps the carry and shifts the whole accumulator right by one bit.
module mul_add_step
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]   acc_hi,
    input  logic [WIDTH-2:0]   acc_lo,
    input  logic [WIDTH-1:0]   m,
    input  logic               mq0,
    output logic [2*WIDTH-1:0] p_next
);

    logic [WIDTH:0] addend_s;
    logic [WIDTH:0] sum_s;

    // Add the gated multiplicand to the upper half; the carry becomes the new MSB after the shift.
    always_comb begin
        addend_s = {(WIDTH+1){1'b0}};
        if (mq0) begin
            addend_s = {1'b0, m};
        end else begin
            addend_s = {(WIDTH+1){1'b0}};
        end
        sum_s  = {1'b0, acc_hi} + addend_s;
        p_next = {sum_s, acc_lo};
    end

endmodule

// File: rtl/seq_mult16_ctrl.sv
// Sequential unsigned shift-and-add multiplier controller sharing one WIDTH-bit adder over WIDTH cycles.
// Optional macro EARLY_TERM_EN: finish early once the remaining multiplier bits are all zero.
module seq_mult16_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_r;
    logic [WIDTH-1:0]     m_r;
    logic [WIDTH-1:0]     mq_r;
    logic [2*WIDTH-1:0]   p_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic [2*WIDTH-1:0]   p_step_s;

    mul_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_hi (p_r[2*WIDTH-1:WIDTH]),
        .acc_lo (p_r[WIDTH-1:1]),
        .m      (m_r),
        .mq0    (mq_r[0]),
        .p_next (p_step_s)
    );

`ifdef EARLY_TERM_EN
    logic [CNT_W-1:0]   shamt_s;
    logic [2*WIDTH-1:0] p_align_s;

    // Partial product sits WIDTH-cnt bits too high; one barrel shift puts it in place.
    always_comb begin
        shamt_s   = CNT_W'(WIDTH) - cnt_r;
        p_align_s = p_r >> shamt_s;
    end
`endif

    // Control FSM with step counter, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            m_r         <= {WIDTH{1'b0}};
            mq_r        <= {WIDTH{1'b0}};
            p_r         <= {(2*WIDTH){1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        m_r        <= a;
                        mq_r       <= b;
                        p_r        <= {(2*WIDTH){1'b0}};
                        cnt_r      <= {CNT_W{1'b0}};
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
`ifdef EARLY_TERM_EN
                    if (mq_r == {WIDTH{1'b0}}) begin
                        p_r         <= p_align_s;
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else
`endif
                    begin
                        p_r   <= p_step_s;
                        mq_r  <= {1'b0, mq_r[WIDTH-1:1]};
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_CNT) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Product stays in p_r untouched until the consumer takes it.
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    p_r         <= {(2*WIDTH){1'b0}};
                    cnt_r       <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign product   = p_r;

endmodule

// File: tb/tb_seq_mult16_ctrl.sv
// Directed self-checking bench for seq_mult16_ctrl (honours EARLY_TERM_EN when defined).
module tb_seq_mult16_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int checks;
    int errors;

    seq_mult16_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected RUN cycles for a given multiplier value.
    function automatic int exp_lat(input logic [15:0] bv);
`ifdef EARLY_TERM_EN
        int k;
        if (bv == 16'h0000) return 1;
        k = 0;
        for (int i = 0; i < 16; i++) if (bv[i]) k = i;
        return (k + 2 > 16) ? 16 : k + 2;
`else
        return 16;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one operand pair for a single accepting edge (caller is at a negedge in IDLE).
    task automatic issue(input logic [15:0] av, input logic [15:0] bv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        step();
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
    endtask

    // Count edges until out_valid, stopping at limit.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!out_valid && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0;
        step(); step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=0", product); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int n;
        out_ready = 1'b1;
        issue(16'd3, 16'd5);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_run_flags busy=%b in_ready=%b exp 1/0", busy, in_ready); end
        wait_done(40, n);
        checks++; if (n !== exp_lat(16'd5)) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", n, exp_lat(16'd5)); end
        checks++; if (product !== 32'h0000000F) begin errors++; $display("FAIL basic_product got=%h exp=0000000f", product); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_cycle out_valid=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle in_ready=%b busy=%b exp 1/0", in_ready, busy); end
    endtask

    task automatic test_max();
        int n;
        out_ready = 1'b1;
        issue(16'hFFFF, 16'hFFFF);
        wait_done(40, n);
        checks++; if (n !== 16) begin errors++; $display("FAIL max_latency got=%0d exp=16", n); end
        checks++; if (product !== 32'hFFFE0001) begin errors++; $display("FAIL max_product got=%h exp=fffe0001", product); end
        step();
    endtask

    task automatic test_hold();
        int n;
        out_ready = 1'b0;
        issue(16'h1234, 16'h00AB);
        wait_done(40, n);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_timeout out_valid=%b exp=1", out_valid); end
        in_valid = 1'b1; a = 16'h0101; b = 16'h0202;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || product !== 32'h000C28BC || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d out_valid=%b product=%h in_ready=%b exp 1/000c28bc/0", i, out_valid, product, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_no_accept busy=%b exp=0", busy); end
    endtask

    task automatic test_abort();
        int n;
        out_ready = 1'b1;
        issue(16'h0007, 16'h8001);
        repeat (6) step();
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_mid_run busy=%b out_valid=%b exp 1/0", busy, out_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || product !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_state out_valid=%b product=%h in_ready=%b busy=%b exp 0/0/1/0", out_valid, product, in_ready, busy);
        end
        issue(16'h00FF, 16'h0101);
        wait_done(40, n);
        checks++; if (product !== 32'h0000FFFF || out_valid !== 1'b1) begin errors++; $display("FAIL abort_next_op product=%h out_valid=%b exp 0000ffff/1", product, out_valid); end
        step();
    endtask

    task automatic test_early();
        int n;
        out_ready = 1'b1;
        issue(16'h1234, 16'h0005);
        wait_done(40, n);
        checks++; if (n !== exp_lat(16'h0005)) begin errors++; $display("FAIL early_b5_latency got=%0d exp=%0d", n, exp_lat(16'h0005)); end
        checks++; if (product !== 32'h00005B04) begin errors++; $display("FAIL early_b5_product got=%h exp=00005b04", product); end
        step();
        issue(16'hABCD, 16'h0000);
        wait_done(40, n);
        checks++; if (n !== exp_lat(16'h0000)) begin errors++; $display("FAIL early_b0_latency got=%0d exp=%0d", n, exp_lat(16'h0000)); end
        checks++; if (product !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL early_b0_product got=%h out_valid=%b exp 0/1", product, out_valid); end
        step();
        issue(16'h0002, 16'h4000);
        wait_done(40, n);
        checks++; if (n !== exp_lat(16'h4000) || product !== 32'h00008000) begin
            errors++;
            $display("FAIL early_b4000 latency=%0d product=%h exp %0d/00008000", n, product, exp_lat(16'h4000));
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa [100];
        logic [15:0] pb [100];
        logic [31:0] expv;
        int n;
        int stall;
        for (int i = 0; i < 100; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = 16'($urandom);
        end
        pa[0] = 16'hFFFF; pb[0] = 16'h0001;
        pa[1] = 16'h0000; pb[1] = 16'hFFFF;
        out_ready = 1'b0;
        in_valid = 1'b1; a = pa[0]; b = pb[0];
        for (int i = 0; i < 100; i++) begin
            step();
            in_valid = 1'b0; a = 16'h5A5A; b = 16'hA5A5;
            wait_done(40, n);
            stall = $urandom_range(0, 3);
            repeat (stall) step();
            expv = 32'(pa[i]) * 32'(pb[i]);
            checks++;
            if (out_valid !== 1'b1 || product !== expv || n !== exp_lat(pb[i])) begin
                errors++;
                $display("FAIL b2b_%0d a=%h b=%h product=%h exp=%h latency=%0d exp_latency=%0d out_valid=%b", i, pa[i], pb[i], product, expv, n, exp_lat(pb[i]), out_valid);
            end
            out_ready = 1'b1;
            if (i < 99) begin
                in_valid = 1'b1; a = pa[i+1]; b = pb[i+1];
            end
            step();
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_retire_%0d out_valid=%b in_ready=%b exp 0/1", i, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_max();
        test_hold();
        test_abort();
        test_early();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
